// File: rtl/mem_read_arbiter_pkg.sv
// Shared constants for the two-port Memory read arbiter: port identifiers,
// Memory read latency and arbitration mode selectors.
package mem_read_arbiter_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int MEM_RD_LATENCY = 1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage : mem_read_arbiter_pkg

// File: rtl/mem_read_arbiter_if.sv
// Bundle of requester handshakes and the Memory read port seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       rdata0;
  logic              rvalid0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       rdata1;
  logic              rvalid1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  req0, addr0, req1, addr1, mem_rdata,
    output rdata0, rvalid0, rdata1, rvalid1, mem_addr, mem_rstrb, busy
  );

  modport master (
    output req0, addr0, req1, addr1, mem_rdata,
    input  rdata0, rvalid0, rdata1, rvalid1, mem_addr, mem_rstrb, busy
  );

endinterface : mem_read_arbiter_if

// File: rtl/mem_read_arbiter_rr_pick2.sv
// Combinational 2-way grant: a lone eligible port wins; on contention the
// port other than last wins (round-robin) or port 0 wins (fixed priority).
module rr_pick2
  import mem_read_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = ARB_RR
) (
  input  logic [1:0] eligible_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    gnt_valid_o = |eligible_i;
    gnt_idx_o   = eligible_i[PORT_DBG] ? PORT_DBG : PORT_CPU;
    if (&eligible_i) begin
      gnt_idx_o = (FIXED_PRIO == ARB_FIXED) ? PORT_CPU : ~last_i;
    end
  end

endmodule : rr_pick2

// File: rtl/mem_read_arbiter.sv
// Shares the single 1-cycle-latency Memory read port between the CPU (port 0)
// and debug/loader (port 1) requesters, steering each returned word back.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = ARB_RR
) (
  input logic               clk,
  input logic               reset,
  mem_read_arbiter_if.slave bus
);

  logic inflight_q, inflight_d;
  logic tag_q, tag_d;
  logic last_q, last_d;

  logic [1:0]        eligible;
  logic              gnt_valid;
  logic              gnt_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic              rvalid0;
  logic              rvalid1;

  // A port whose own read is in flight sits out, which also blocks a
  // re-issue during its rvalid cycle. Reset masks everything combinationally
  // so no strobe or response escapes while it is asserted.
  always_comb begin
    eligible[PORT_CPU] = bus.req0 && !(inflight_q && (tag_q == PORT_CPU)) && !reset;
    eligible[PORT_DBG] = bus.req1 && !(inflight_q && (tag_q == PORT_DBG)) && !reset;
  end

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .eligible_i  (eligible),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign mem_addr      = (gnt_valid && (gnt_idx == PORT_DBG)) ? bus.addr1 : bus.addr0;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_rstrb = gnt_valid;

  always_comb begin
    inflight_d = gnt_valid;
    tag_d      = tag_q;
    last_d     = last_q;
    if (gnt_valid) begin
      tag_d  = gnt_idx;
      last_d = gnt_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      tag_q      <= PORT_CPU;
      last_q     <= PORT_DBG;
    end else begin
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
    end
  end

  // Memory data arrives MEM_RD_LATENCY cycle after the strobe, so the
  // registered tag alone decides which port sees it.
  assign rvalid0 = inflight_q && (tag_q == PORT_CPU) && !reset;
  assign rvalid1 = inflight_q && (tag_q == PORT_DBG) && !reset;

  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata0  = rvalid0 ? bus.mem_rdata : 32'h0;
  assign bus.rdata1  = rvalid1 ? bus.mem_rdata : 32'h0;
  assign bus.busy    = inflight_q && !reset;

endmodule : mem_read_arbiter

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single read port of the 256-word instruction/data Memory between two requesters: port 0 (CPU fetch/load) and port 1 (debug/loader read-back).
- The Memory read port has 1-cycle latency: `mem_rdata` is valid the cycle after `mem_rstrb`, and it holds until the next strobe.
- The arbiter issues at most one strobe per cycle, tags it with the winning port, and steers the returned word back to that port with a 1-cycle valid pulse.
- It sits between the core/debug logic and the Memory; no other block drives the Memory read port.

Parameters:
- ADDR_W, 32, byte-address width of all address ports.
- FIXED_PRIO, 0, arbitration mode. 0 = round-robin. 1 = port 0 always wins contention.

Ports:
- `clk` in 1 — system clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `req0` in 1 — port 0 read request; held high until `rvalid0`.
- `addr0` in ADDR_W — port 0 byte address; stable while `req0` is high.
- `rdata0` out 32 — port 0 read data; meaningful only when `rvalid0`=1.
- `rvalid0` out 1 — 1-cycle pulse: `rdata0` carries the word for port 0's request.
- `req1` in 1 — port 1 read request; same rules as `req0`.
- `addr1` in ADDR_W — port 1 byte address.
- `rdata1` out 32 — port 1 read data.
- `rvalid1` out 1 — port 1 completion pulse.
- `mem_addr` out ADDR_W — to Memory; the granted port's address.
- `mem_rstrb` out 1 — to Memory; read strobe.
- `mem_rdata` in 32 — from Memory; valid the cycle after `mem_rstrb`.
- `busy` out 1 — a read is in flight (`mem_rstrb` was high last cycle).

Behaviour:
- Registered state:
  - `inflight` (1b): a strobe was issued last cycle.
  - `tag` (1b): the port that strobe belongs to.
  - `last` (1b): the port most recently granted.
- Reset (sync, takes priority over everything): `inflight`=0, `tag`=0, `last`=1, so port 0 wins first contention.
- Outputs during and after reset: `rvalid0`/`rvalid1`=0, `mem_rstrb`=0, `busy`=0, `mem_addr`=`addr0`.
- Eligibility: port i is eligible when `req_i`=1 AND NOT (`inflight` AND `tag`==i). A port therefore never has two reads outstanding, and is not re-issued in its own `rvalid` cycle while its `req` is still high.
- Grant (combinational, every cycle):
  - Only one port eligible: that port wins.
  - Both eligible, FIXED_PRIO=0: the port != `last` wins.
  - Both eligible, FIXED_PRIO=1: port 0 wins.
  - Neither eligible: no grant.
- Memory drive:
  - `mem_rstrb` = any grant.
  - `mem_addr` = granted port's address; `addr0` when there is no grant.
  - Both are combinational from the `req`/`addr` inputs and registered state. The Memory samples them at the edge.
- Register updates at the edge:
  - `inflight` <= `mem_rstrb`.
  - If `mem_rstrb`: `tag` <= granted port and `last` <= granted port.
- Response (1-cycle latency from strobe):
  - `rvalid_i` = `inflight` AND `tag`==i.
  - `rdata0` and `rdata1` both = `mem_rdata`, passed through combinationally and gated only by `rvalid`.
- Requester contract: drop `req`, or present a new address, on the edge that ends its `rvalid` cycle. A new `req` from that port is eligible the cycle after `rvalid`.
- Throughput:
  - One port alone: one read every 2 cycles.
  - Both ports requesting: alternate every cycle, 100% Memory utilisation.
- Starvation: impossible when FIXED_PRIO=0. When FIXED_PRIO=1, port 1 still wins every cycle in which port 0 is ineligible because its own read is in flight.
- `busy` = `inflight`.
- `req` dropped while in flight: the response still pulses `rvalid`, and the requester ignores it.
- Reset mid-read: the in-flight response is discarded, so no `rvalid` follows reset.
- Address bits [1:0] pass through unchanged; the Memory ignores them. No alignment check.

Decomposition:
- Shared package holds:
  - PORT_CPU=0 and PORT_DBG=1.
  - MEM_RD_LATENCY=1.
  - Arbitration mode constants ARB_RR=0 and ARB_FIXED=1.
- One natural sub-module, `rr_pick2`: combinational 2-way grant from eligible[1:0], `last` and FIXED_PRIO, returning `gnt_valid` and `gnt_idx`.
- `inflight`, `tag`, `last` and the response steering stay in the top module.

Test Plan:
- Reset, then `req0`=1, `addr0`=0x08, `req1`=0 → cycle 0: `mem_rstrb`=1, `mem_addr`=0x08. Cycle 1: `rvalid0`=1, `rdata0`=MEM[2], `mem_rstrb`=0, `busy`=1.
- `req0` and `req1` both held high, `addr0`=0x00, `addr1`=0x04, FIXED_PRIO=0 → grants 0,1,0,1 on consecutive cycles. `mem_rstrb`=1 every cycle. `rvalid0`/`rvalid1` alternate with MEM[0]/MEM[1].
- Same stimulus with FIXED_PRIO=1 → port 0 granted every other cycle. Port 1 is granted only in port 0's `rvalid` cycles, with no starvation.
- `req1` only, `addr1`=0x10 held for 6 cycles → strobes in cycles 0, 2, 4. `rvalid1` in cycles 1, 3, 5 with MEM[4]. Never two consecutive strobes.
- Strobe issued for port 1, `reset`=1 in the next cycle → `rvalid1`=0 in that cycle. After reset: `inflight`=0, and first contention goes to port 0.
- `req0` dropped in the cycle after its grant → `rvalid0` still pulses once. No further strobes while both `req`s are low.
